riscv_xu_sequencer: RTL and testbench

RISCV_XU_SEQUENCER -- requirements
Module: riscv_xu_sequencer

---
 rtl/riscv_xu_sequencer.sv | 142 ++++++++++++++
 tb/tb_riscv_xu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_xu_sequencer.sv
// Purpose : sequences one multi-cycle op (mul/div/...) at a time from execute into an
//           attached unit, stalls the pipe while it runs, and holds its result for writeback.
// Latency : start in the issue cycle (combinational); result_valid the cycle after the selected done.
// Backpr. : stall is raised from the issue cycle until done; a completed result waits in HOLD
//           while globstall is high. The units themselves have no backpressure.
// Ports   : clk/rst; issue, unitsel, ctrl, rs1/rs2 data, globstall, flush from execute;
//           unit_done/unit_result from the units; unit_start/kill/rs1/rs2/ctrl to the units;
//           stall, result, result_valid, timeout and a saturating busy_cycles counter out.
module riscv_xu_sequencer #(
  parameter int XLEN   = 64,
  parameter int NUNITS = 2,
  parameter int CTRLW  = 4,
  parameter int MAXLAT = 64,
  localparam int UIDW  = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
  input  logic                   i_riscv_xu_clk,
  input  logic                   i_riscv_xu_rst,
  input  logic                   i_riscv_xu_issue,
  input  logic [UIDW-1:0]        i_riscv_xu_unitsel,
  input  logic [CTRLW-1:0]       i_riscv_xu_ctrl,
  input  logic [XLEN-1:0]        i_riscv_xu_rs1data,
  input  logic [XLEN-1:0]        i_riscv_xu_rs2data,
  input  logic                   i_riscv_xu_globstall,
  input  logic                   i_riscv_xu_flush,
  input  logic [NUNITS-1:0]      i_riscv_xu_unit_done,
  input  logic [NUNITS*XLEN-1:0] i_riscv_xu_unit_result,
  output logic [NUNITS-1:0]      o_riscv_xu_unit_start,
  output logic                   o_riscv_xu_unit_kill,
  output logic [XLEN-1:0]        o_riscv_xu_unit_rs1,
  output logic [XLEN-1:0]        o_riscv_xu_unit_rs2,
  output logic [CTRLW-1:0]       o_riscv_xu_unit_ctrl,
  output logic                   o_riscv_xu_stall,
  output logic [XLEN-1:0]        o_riscv_xu_result,
  output logic                   o_riscv_xu_result_valid,
  output logic                   o_riscv_xu_timeout,
  output logic [15:0]            o_riscv_xu_busy_cycles
);

  localparam int LATW = $clog2(MAXLAT);
  localparam logic [LATW-1:0] LAT_LAST = LATW'(MAXLAT - 1);
  // One extra bit so unitsel values beyond a non-power-of-two NUNITS compare correctly.
  localparam logic [UIDW:0] NUNITS_W = (UIDW + 1)'(NUNITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_HOLD
  } state_t;

  state_t          state;
  logic [UIDW-1:0] sel_q;
  logic [LATW-1:0] lat_cnt;

  logic            sel_valid;
  logic            accept;
  logic            sel_done;
  logic [XLEN-1:0] sel_result;
  logic            expire;

  assign sel_valid = ({1'b0, i_riscv_xu_unitsel} < NUNITS_W);
  assign accept    = (state == S_IDLE) && i_riscv_xu_issue && !i_riscv_xu_flush && sel_valid;

  // Only the unit latched at start is watched; done pulses from any other unit are ignored.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    for (int u = 0; u < NUNITS; u++) begin
      if (sel_q == UIDW'(u)) begin
        sel_done   = i_riscv_xu_unit_done[u];
        sel_result = i_riscv_xu_unit_result[u*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_riscv_xu_unit_start = '0;
    for (int u = 0; u < NUNITS; u++) begin
      if (accept && (i_riscv_xu_unitsel == UIDW'(u))) begin
        o_riscv_xu_unit_start[u] = 1'b1;
      end
    end
  end

  // A done arriving on the last allowed cycle still counts as a normal completion.
  assign expire = (state == S_BUSY) && !sel_done && (lat_cnt == LAT_LAST);

  // Flush outranks timeout: a flushed op reports kill but never a timeout.
  assign o_riscv_xu_timeout      = expire && !i_riscv_xu_flush;
  assign o_riscv_xu_unit_kill    = (state == S_BUSY) && (i_riscv_xu_flush || expire);
  assign o_riscv_xu_stall        = accept || (state == S_BUSY);
  assign o_riscv_xu_result_valid = (state == S_HOLD);

  always_ff @(posedge i_riscv_xu_clk or posedge i_riscv_xu_rst) begin
    if (i_riscv_xu_rst) begin
      state                  <= S_IDLE;
      sel_q                  <= '0;
      lat_cnt                <= '0;
      o_riscv_xu_unit_rs1    <= '0;
      o_riscv_xu_unit_rs2    <= '0;
      o_riscv_xu_unit_ctrl   <= '0;
      o_riscv_xu_result      <= '0;
      o_riscv_xu_busy_cycles <= '0;
    end else begin
      if ((state == S_BUSY) && (o_riscv_xu_busy_cycles != 16'hFFFF)) begin
        o_riscv_xu_busy_cycles <= o_riscv_xu_busy_cycles + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            o_riscv_xu_unit_rs1  <= i_riscv_xu_rs1data;
            o_riscv_xu_unit_rs2  <= i_riscv_xu_rs2data;
            o_riscv_xu_unit_ctrl <= i_riscv_xu_ctrl;
            sel_q                <= i_riscv_xu_unitsel;
            lat_cnt              <= '0;
            state                <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_riscv_xu_flush) begin
            state <= S_IDLE;
          end else if (sel_done) begin
            o_riscv_xu_result <= sel_result;
            state             <= S_HOLD;
          end else if (expire) begin
            o_riscv_xu_result <= '0;
            state             <= S_HOLD;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (i_riscv_xu_flush || !i_riscv_xu_globstall) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_xu_sequencer.sv
// Directed bench for riscv_xu_sequencer: three units so an out-of-range unitsel exists,
// MAXLAT=8 for a short timeout. Inputs change on the falling edge, outputs are checked
// 2 time units later; a monitor pops expected results from a queue as they complete.
module tb_riscv_xu_sequencer;
  localparam int XLEN   = 64;
  localparam int NUNITS = 3;
  localparam int CTRLW  = 4;
  localparam int MAXLAT = 8;
  localparam int UIDW   = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   issue = 1'b0;
  logic [UIDW-1:0]        unitsel = '0;
  logic [CTRLW-1:0]       ctrl = '0;
  logic [XLEN-1:0]        rs1 = '0;
  logic [XLEN-1:0]        rs2 = '0;
  logic                   globstall = 1'b0;
  logic                   flush = 1'b0;
  logic [NUNITS-1:0]      udone = '0;
  logic [NUNITS*XLEN-1:0] ures = '0;

  logic [NUNITS-1:0]      start;
  logic                   kill;
  logic [XLEN-1:0]        unit_rs1;
  logic [XLEN-1:0]        unit_rs2;
  logic [CTRLW-1:0]       unit_ctrl;
  logic                   stall;
  logic [XLEN-1:0]        result;
  logic                   res_valid;
  logic                   timeout;
  logic [15:0]            busy_cycles;

  riscv_xu_sequencer #(
    .XLEN(XLEN), .NUNITS(NUNITS), .CTRLW(CTRLW), .MAXLAT(MAXLAT)
  ) dut (
    .i_riscv_xu_clk          (clk),
    .i_riscv_xu_rst          (rst),
    .i_riscv_xu_issue        (issue),
    .i_riscv_xu_unitsel      (unitsel),
    .i_riscv_xu_ctrl         (ctrl),
    .i_riscv_xu_rs1data      (rs1),
    .i_riscv_xu_rs2data      (rs2),
    .i_riscv_xu_globstall    (globstall),
    .i_riscv_xu_flush        (flush),
    .i_riscv_xu_unit_done    (udone),
    .i_riscv_xu_unit_result  (ures),
    .o_riscv_xu_unit_start   (start),
    .o_riscv_xu_unit_kill    (kill),
    .o_riscv_xu_unit_rs1     (unit_rs1),
    .o_riscv_xu_unit_rs2     (unit_rs2),
    .o_riscv_xu_unit_ctrl    (unit_ctrl),
    .o_riscv_xu_stall        (stall),
    .o_riscv_xu_result       (result),
    .o_riscv_xu_result_valid (res_valid),
    .o_riscv_xu_timeout      (timeout),
    .o_riscv_xu_busy_cycles  (busy_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  // Scoreboard: a result is consumed in the HOLD cycle that leaves (globstall low).
  always @(negedge clk) begin
    #3;
    if (!rst && res_valid && !globstall) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 64'(res_valid), 64'd0);
      else                   chk("sb_result", result, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    nxt(); settle();
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_kill", 64'(kill), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_rs1", unit_rs1, 64'd0);
    chk("rst_rs2", unit_rs2, 64'd0);
    chk("rst_ctrl", 64'(unit_ctrl), 64'd0);
    chk("rst_busy", 64'(busy_cycles), 64'd0);
    nxt(); rst = 1'b0;

    // Div 100/7, done three cycles after start
    nxt(); issue = 1'b1; unitsel = 2'd1; rs1 = 64'd100; rs2 = 64'd7; ctrl = 4'h3;
    exp_q.push_back(64'd14);
    settle();
    chk("a_start", 64'(start), 64'b010);
    chk("a_stall0", 64'(stall), 64'd1);
    nxt(); rs1 = 64'd5; settle();  // issue held high while busy is ignored
    chk("a_start_once", 64'(start), 64'd0);
    chk("a_stall1", 64'(stall), 64'd1);
    chk("a_rs1", unit_rs1, 64'd100);
    chk("a_rs2", unit_rs2, 64'd7);
    chk("a_ctrl", 64'(unit_ctrl), 64'd3);
    nxt(); settle();
    chk("a_stall2", 64'(stall), 64'd1);
    chk("a_start2", 64'(start), 64'd0);
    nxt(); issue = 1'b0; udone = 3'b010; ures[127:64] = 64'd14; settle();
    chk("a_stall3", 64'(stall), 64'd1);
    chk("a_valid_early", 64'(res_valid), 64'd0);
    nxt(); udone = '0; settle();
    chk("a_valid", 64'(res_valid), 64'd1);
    chk("a_result", result, 64'd14);
    chk("a_stall4", 64'(stall), 64'd0);
    chk("a_busy", 64'(busy_cycles), 64'd3);
    nxt(); settle();
    chk("a_valid_off", 64'(res_valid), 64'd0);
    chk("a_stall5", 64'(stall), 64'd0);
    chk("a_rs1_hold", unit_rs1, 64'd100);

    // Done from the wrong unit is ignored
    nxt(); issue = 1'b1; unitsel = 2'd1; rs1 = 64'd9; settle();
    chk("b_stall0", 64'(stall), 64'd1);
    nxt(); issue = 1'b0; udone = 3'b001; ures[63:0] = 64'd999; settle();
    chk("b_stall1", 64'(stall), 64'd1);
    nxt(); udone = '0; settle();
    chk("b_stall2", 64'(stall), 64'd1);
    chk("b_valid", 64'(res_valid), 64'd0);
    nxt(); udone = 3'b010; ures[127:64] = 64'd55; exp_q.push_back(64'd55); settle();
    nxt(); udone = '0; settle();
    chk("b_valid2", 64'(res_valid), 64'd1);
    chk("b_result", result, 64'd55);

    // Completion held by globstall for three cycles; issue in HOLD ignored
    nxt(); issue = 1'b1; unitsel = 2'd0; exp_q.push_back(64'd42); settle();
    chk("c_start", 64'(start), 64'b001);
    nxt(); issue = 1'b0; udone = 3'b001; ures[63:0] = 64'd42; settle();
    for (int i = 0; i < 3; i++) begin
      nxt(); udone = '0; globstall = 1'b1; issue = 1'b1; settle();
      chk("c_hold_valid", 64'(res_valid), 64'd1);
      chk("c_hold_result", result, 64'd42);
      chk("c_hold_stall", 64'(stall), 64'd0);
      chk("c_hold_start", 64'(start), 64'd0);
    end
    nxt(); globstall = 1'b0; issue = 1'b0; settle();
    chk("c_last_valid", 64'(res_valid), 64'd1);
    chk("c_last_result", result, 64'd42);
    chk("c_last_stall", 64'(stall), 64'd0);
    nxt(); settle();
    chk("c_valid_off", 64'(res_valid), 64'd0);

    // Flush coincident with the selected done
    nxt(); issue = 1'b1; unitsel = 2'd1; settle();
    nxt(); issue = 1'b0; udone = 3'b010; ures[127:64] = 64'd77; flush = 1'b1; settle();
    chk("d_kill", 64'(kill), 64'd1);
    chk("d_timeout", 64'(timeout), 64'd0);
    nxt(); udone = '0; flush = 1'b0; settle();
    chk("d_stall", 64'(stall), 64'd0);
    chk("d_valid", 64'(res_valid), 64'd0);
    chk("d_kill_off", 64'(kill), 64'd0);
    nxt(); settle();
    chk("d_valid2", 64'(res_valid), 64'd0);

    // Timeout: no done, MAXLAT=8 -> kill/timeout on BUSY cycle 8
    nxt(); issue = 1'b1; unitsel = 2'd0; ures[63:0] = 64'hDEAD; exp_q.push_back(64'd0); settle();
    for (int i = 1; i < 8; i++) begin
      nxt(); issue = 1'b0; settle();
      chk("e_no_timeout", 64'(timeout), 64'd0);
      chk("e_no_kill", 64'(kill), 64'd0);
      chk("e_stall", 64'(stall), 64'd1);
    end
    nxt(); settle();
    chk("e_timeout", 64'(timeout), 64'd1);
    chk("e_kill", 64'(kill), 64'd1);
    nxt(); settle();
    chk("e_valid", 64'(res_valid), 64'd1);
    chk("e_result", result, 64'd0);
    chk("e_timeout_off", 64'(timeout), 64'd0);
    chk("e_kill_off", 64'(kill), 64'd0);
    nxt(); settle();

    // Out-of-range unit: no start, no stall
    nxt(); issue = 1'b1; unitsel = 2'd3; settle();
    chk("f_start", 64'(start), 64'd0);
    chk("f_stall", 64'(stall), 64'd0);
    nxt(); settle();
    chk("f_stall2", 64'(stall), 64'd0);
    issue = 1'b0;

    // Reset in the middle of BUSY, then a fresh op
    nxt(); issue = 1'b1; unitsel = 2'd1; settle();
    nxt(); issue = 1'b0; settle();
    nxt(); settle();
    nxt(); rst = 1'b1; settle();
    chk("g_kill", 64'(kill), 64'd0);
    chk("g_stall", 64'(stall), 64'd0);
    chk("g_busy_rst", 64'(busy_cycles), 64'd0);
    chk("g_valid", 64'(res_valid), 64'd0);
    chk("g_rs1", unit_rs1, 64'd0);
    nxt(); rst = 1'b0; udone = 3'b010; ures[127:64] = 64'd123; settle();
    chk("g_stale_valid", 64'(res_valid), 64'd0);
    chk("g_stale_stall", 64'(stall), 64'd0);
    nxt(); udone = '0; issue = 1'b1; unitsel = 2'd0; rs1 = 64'd11; exp_q.push_back(64'd5); settle();
    chk("g_start", 64'(start), 64'b001);
    nxt(); issue = 1'b0; settle();
    nxt(); udone = 3'b001; ures[63:0] = 64'd5; settle();
    nxt(); udone = '0; settle();
    chk("g_valid2", 64'(res_valid), 64'd1);
    chk("g_result", result, 64'd5);
    chk("g_busy", 64'(busy_cycles), 64'd2);
    chk("g_rs1_new", unit_rs1, 64'd11);
    nxt(); settle();
    nxt(); settle();

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
